// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared sizing constants and FSM state encoding for the
// single-port RAM controller.
//   ADDR_W / DATA_W / DEPTH : RAM geometry (32 words of 32 bits)
//   state_e                 : controller FSM states
//   clr_last                : true when the clear counter holds the final address
package ram_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RSP     = 3'd4,
    CLR     = 3'd5
  } state_e;

  // Clear sequence ends after the highest address has been written.
  function automatic logic clr_last(input logic [ADDR_W-1:0] cnt);
    return (cnt == ADDR_W'(DEPTH - 1));
  endfunction

endpackage

// File: rtl/ram_ctrl.sv
// ram_ctrl: request/response front end for a 32x32 synchronous single-port RAM.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (req_ready combinational)
//   req_wr, req_addr, req_wdata : request type, word address, write data
//   clr_start               : pulse in IDLE to zero all 32 words
//   busy                    : high whenever the FSM is not IDLE
//   rsp_valid/rsp_ready, rsp_rdata : read response handshake and data
//   ram_cen, ram_wen, ram_addr, ram_din : registered RAM controls
//   ram_dout                : RAM read data, valid one cycle after a read strobe
module ram_ctrl
  import ram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr_start,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e              state_r;
  state_e              next_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   cnt_nxt_s;
  logic                cen_nxt_s;
  logic                wen_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic [DATA_W-1:0]   din_nxt_s;

  // Handshake: a request is only taken in IDLE, and a clear pulse pre-empts it.
  assign req_ready = (state_r == IDLE) && !clr_start;

  // Next-state and next RAM-control decode. RAM controls are computed for the
  // state being entered so the registered outputs line up with that state.
  always_comb begin
    next_s     = state_r;
    cnt_nxt_s  = cnt_r;
    cen_nxt_s  = 1'b0;
    wen_nxt_s  = 1'b0;
    addr_nxt_s = ram_addr;
    din_nxt_s  = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (clr_start) begin
          next_s     = CLR;
          cnt_nxt_s  = {ADDR_W{1'b0}};
          cen_nxt_s  = 1'b1;
          wen_nxt_s  = 1'b1;
          addr_nxt_s = {ADDR_W{1'b0}};
        end else if (req_valid) begin
          cen_nxt_s  = 1'b1;
          addr_nxt_s = req_addr;
          if (req_wr) begin
            next_s    = WR;
            wen_nxt_s = 1'b1;
            din_nxt_s = req_wdata;
          end else begin
            next_s    = RD;
          end
        end else begin
          next_s = IDLE;
        end
      end
      WR:      next_s = IDLE;
      RD:      next_s = RD_WAIT;
      RD_WAIT: next_s = RSP;
      RSP: begin
        if (rsp_ready) begin
          next_s = IDLE;
        end else begin
          next_s = RSP;
        end
      end
      CLR: begin
        if (clr_last(cnt_r)) begin
          next_s = IDLE;
        end else begin
          cnt_nxt_s  = cnt_r + 5'd1;
          cen_nxt_s  = 1'b1;
          wen_nxt_s  = 1'b1;
          addr_nxt_s = cnt_r + 5'd1;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // State, clear counter and registered RAM controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {ADDR_W{1'b0}};
      busy     <= 1'b0;
      ram_cen  <= 1'b0;
      ram_wen  <= 1'b0;
      ram_addr <= {ADDR_W{1'b0}};
      ram_din  <= {DATA_W{1'b0}};
    end else begin
      state_r  <= next_s;
      cnt_r    <= cnt_nxt_s;
      busy     <= (next_s != IDLE);
      ram_cen  <= cen_nxt_s;
      ram_wen  <= wen_nxt_s;
      ram_addr <= addr_nxt_s;
      ram_din  <= din_nxt_s;
    end
  end

  // Read response: data is captured at the end of RD_WAIT (RAM output valid
  // then) and held untouched until the next read reaches RD_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
    end else begin
      rsp_valid <= (next_s == RSP);
      if (state_r == RD_WAIT) begin
        rsp_rdata <= ram_dout;
      end else begin
        rsp_rdata <= rsp_rdata;
      end
    end
  end

endmodule
